field_decode: RTL and testbench

- Parametrised successor to the RX block-number decoder.
- Captures a multi-byte field from the received Ethernet byte stream: skips a programmable byte offset, assembles FIELD_BYTES bytes in the configured byte order, and presents the result with a one-cycle valid strobe.
- Flags segments that end before the field is complete.
- Sits in the RX path and is enabled by the packet parser for the span of the header region of interest; used for block numbers, opcodes, error codes and ports.

---
 rtl/field_decode.sv | 88 ++++++++
 tb/tb_field_decode.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/field_decode.sv
// rtl/field_decode.sv - captures a multi-byte field at a fixed offset within an enabled byte segment
module field_decode #(
  parameter int FIELD_BYTES = 2,
  parameter int OFFSET      = 0,
  parameter int LSB_FIRST   = 0,
  parameter int CNT_W       = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic [7:0]               eth_data,
  output logic [8*FIELD_BYTES-1:0] field,
  output logic                     field_valid,
  output logic                     field_short
);

  localparam int W = 8 * FIELD_BYTES;
  localparam logic [CNT_W-1:0] OFF_C  = CNT_W'(OFFSET);
  localparam logic [CNT_W-1:0] LAST_K = CNT_W'(FIELD_BYTES - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] k;
  logic [W-1:0]     sr;
  logic [W-1:0]     sr_next;
  logic             done;
  logic             en_d;
  logic             in_window;
  logic             is_last;

  // Position within the field; bytes before OFFSET wrap to a large value and fall outside the window
  always_comb begin
    k         = cnt - OFF_C;
    in_window = en && (k <= LAST_K);
    is_last   = in_window && (k == LAST_K);
  end

  // Assemble the current byte into the shift register in the configured byte order
  always_comb begin
    sr_next = sr;
    if (LSB_FIRST != 0) begin
      for (int i = 0; i < FIELD_BYTES; i++) begin
        if (k == CNT_W'(i)) begin
          sr_next[8*i +: 8] = eth_data;
        end
      end
    end else begin
      sr_next = (sr << 8) | W'(eth_data);
    end
  end

  // Byte counter, assembly, completion and short-segment detection
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= '0;
      sr          <= '0;
      done        <= 1'b0;
      en_d        <= 1'b0;
      field       <= '0;
      field_valid <= 1'b0;
      field_short <= 1'b0;
    end else begin
      field_valid <= 1'b0;
      field_short <= 1'b0;
      en_d        <= en;
      if (en) begin
        if (cnt != '1) begin
          cnt <= cnt + 1'b1;
        end
        if (in_window) begin
          sr <= sr_next;
        end
        if (is_last) begin
          field       <= sr_next;
          field_valid <= 1'b1;
          done        <= 1'b1;
        end
      end else begin
        cnt  <= '0;
        done <= 1'b0;
        sr   <= '0;
        if (en_d && !done) begin
          field_short <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_field_decode.sv
// tb/tb_field_decode.sv - self-checking bench for field_decode over three parameter sets
module tb_field_decode;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic [7:0]  eth_data = 8'h00;

  logic [15:0] field0, field1;
  logic [31:0] field2;
  logic        valid0, valid1, valid2;
  logic        short0, short1, short2;

  int n_pass  = 0;
  int n_total = 0;

  // instance parameters: 0 = default, 1 = OFFSET 2, 2 = LSB-first 4-byte
  int fb_p[3]  = '{2, 2, 4};
  int off_p[3] = '{0, 2, 0};
  int lsb_p[3] = '{0, 0, 1};

  logic [7:0]  seg_q[$];
  logic        prev_en = 1'b0;
  logic [63:0] exp_field[3];
  logic        exp_valid[3];
  logic        exp_short[3];

  always #5 clk = ~clk;

  field_decode #(.FIELD_BYTES(2), .OFFSET(0), .LSB_FIRST(0), .CNT_W(8)) dut0 (
    .clk(clk), .reset(reset), .en(en), .eth_data(eth_data),
    .field(field0), .field_valid(valid0), .field_short(short0));

  field_decode #(.FIELD_BYTES(2), .OFFSET(2), .LSB_FIRST(0), .CNT_W(8)) dut1 (
    .clk(clk), .reset(reset), .en(en), .eth_data(eth_data),
    .field(field1), .field_valid(valid1), .field_short(short1));

  field_decode #(.FIELD_BYTES(4), .OFFSET(0), .LSB_FIRST(1), .CNT_W(8)) dut2 (
    .clk(clk), .reset(reset), .en(en), .eth_data(eth_data),
    .field(field2), .field_valid(valid2), .field_short(short2));

  function automatic logic [63:0] assemble(input int fb, input int off, input int lsb);
    logic [63:0] v;
    v = 64'd0;
    for (int j = 0; j < fb; j++) begin
      if (lsb != 0) v = v | (64'(seg_q[off+j]) << (8*j));
      else          v = (v << 8) | 64'(seg_q[off+j]);
    end
    return v;
  endfunction

  task automatic model(input logic r, input logic e, input logic [7:0] d);
    for (int i = 0; i < 3; i++) begin
      exp_valid[i] = 1'b0;
      exp_short[i] = 1'b0;
    end
    if (r) begin
      seg_q.delete();
      for (int i = 0; i < 3; i++) exp_field[i] = 64'd0;
    end else if (e) begin
      seg_q.push_back(d);
      for (int i = 0; i < 3; i++) begin
        if (seg_q.size() == off_p[i] + fb_p[i]) begin
          exp_field[i] = assemble(fb_p[i], off_p[i], lsb_p[i]);
          exp_valid[i] = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (prev_en && (seg_q.size() < off_p[i] + fb_p[i])) exp_short[i] = 1'b1;
      end
      seg_q.delete();
    end
    prev_en = r ? 1'b0 : e;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
  endtask

  task automatic compare_all();
    check("field0", {48'd0, field0}, exp_field[0]);
    check("field1", {48'd0, field1}, exp_field[1]);
    check("field2", {32'd0, field2}, exp_field[2]);
    check("valid0", {63'd0, valid0}, {63'd0, exp_valid[0]});
    check("valid1", {63'd0, valid1}, {63'd0, exp_valid[1]});
    check("valid2", {63'd0, valid2}, {63'd0, exp_valid[2]});
    check("short0", {63'd0, short0}, {63'd0, exp_short[0]});
    check("short1", {63'd0, short1}, {63'd0, exp_short[1]});
    check("short2", {63'd0, short2}, {63'd0, exp_short[2]});
    check("excl0", {63'd0, valid0 & short0}, 64'd0);
    check("excl2", {63'd0, valid2 & short2}, 64'd0);
  endtask

  task automatic step(input logic r, input logic e, input logic [7:0] d);
    @(negedge clk);
    reset    = r;
    en       = e;
    eth_data = d;
    @(posedge clk);
    model(r, e, d);
    #1;
    compare_all();
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    int len;
    int gap;

    // reset state
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b1, 8'h5A);

    // legacy timing: 0x00,0x01
    step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b1, 8'h01);
    check("tp1_valid_after_last", {63'd0, valid0}, 64'd1);
    idle();
    idle();
    check("tp1_field_holds", {48'd0, field0}, 64'h0001);

    // short segment: one byte then en low
    step(1'b0, 1'b1, 8'hFF);
    idle();
    check("tp4_short", {63'd0, short0}, 64'd1);
    check("tp4_field_kept", {48'd0, field0}, 64'h0001);
    idle();

    // offset capture, trailing byte ignored
    step(1'b0, 1'b1, 8'hAA);
    step(1'b0, 1'b1, 8'hBB);
    step(1'b0, 1'b1, 8'h12);
    step(1'b0, 1'b1, 8'h34);
    check("tp2_field1", {48'd0, field1}, 64'h1234);
    step(1'b0, 1'b1, 8'h56);
    check("tp2_no_second_valid", {63'd0, valid1}, 64'd0);
    idle();

    // LSB-first 4-byte field
    step(1'b0, 1'b1, 8'h78);
    step(1'b0, 1'b1, 8'h56);
    step(1'b0, 1'b1, 8'h34);
    step(1'b0, 1'b1, 8'h12);
    check("tp3_field2", {32'd0, field2}, 64'h12345678);
    idle();

    // back-to-back segments with one idle cycle
    step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b1, 8'h05);
    check("tp5_first", {48'd0, field0}, 64'h0005);
    idle();
    step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b1, 8'h06);
    check("tp5_second", {48'd0, field0}, 64'h0006);
    idle();

    // reset mid-segment, then a full segment
    step(1'b0, 1'b1, 8'h77);
    step(1'b1, 1'b1, 8'h88);
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b1, 8'h09);
    check("tp6_field", {48'd0, field0}, 64'h0009);
    idle();

    // en held high through reset deassertion
    step(1'b1, 1'b1, 8'hC3);
    step(1'b0, 1'b1, 8'hAB);
    step(1'b0, 1'b1, 8'hCD);
    check("en_thru_reset", {48'd0, field0}, 64'hABCD);
    idle();

    // long segment drives the counter into saturation
    for (int n = 0; n < 300; n++) step(1'b0, 1'b1, 8'($urandom));
    idle();
    idle();

    // randomized segments, gaps and occasional resets
    for (int s = 0; s < 60; s++) begin
      len = $urandom_range(1, 9);
      for (int b = 0; b < len; b++) begin
        if ($urandom_range(0, 39) == 0) step(1'b1, 1'($urandom), 8'($urandom));
        else step(1'b0, 1'b1, 8'($urandom));
      end
      gap = $urandom_range(1, 3);
      for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 8'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
